// File: rtl/ex_mem_stage_pkg.sv
// Shared types and defaults for the EX/MEM pipeline boundary.
// Holds the ALU control encodings and the EX->MEM control bundle.
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_ctrl_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic branch_ne;
    } ex_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: EX-side inputs, hazard controls, MEM-side and forwarding outputs.
// The master modport is the surrounding pipeline; slave is the stage register.
interface ex_mem_stage_if
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
);
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_branch_ne;
    logic [DATA_W-1:0] ex_branch_target;
    logic              stall;
    logic              flush;

    logic              ex_ready;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_W-1:0]  mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic              fwd_valid;

    modport master (
        output ex_valid, ex_result, ex_zero, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_branch_ne, ex_branch_target, stall, flush,
        input  ex_ready, mem_valid, mem_result, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write,
               branch_taken, branch_target, fwd_valid
    );

    modport slave (
        input  ex_valid, ex_result, ex_zero, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_branch_ne, ex_branch_target, stall, flush,
        output ex_ready, mem_valid, mem_result, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write,
               branch_taken, branch_target, fwd_valid
    );

endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Conditional branch decision from the ALU zero flag (beq/bne).
// Purely combinational so it can also sit in the EX stage for early resolution.
module branch_resolve (
    input  logic branch_i,
    input  logic zero_i,
    input  logic ne_i,
    output logic taken_o
);

    assign taken_o = branch_i & (zero_i ^ ne_i);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU result and controls for the MEM stage,
// issues a one-cycle branch redirect and exports a forwarding view.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);

    ex_ctrl_t          ex_ctrl;
    logic              taken_now;

    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] result_q,     result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [REG_W-1:0]  rd_q,         rd_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              taken_q,      taken_d;
    logic [DATA_W-1:0] target_q,     target_d;

    assign ex_ctrl = '{
        reg_write: bus.ex_reg_write,
        mem_read:  bus.ex_mem_read,
        mem_write: bus.ex_mem_write,
        branch:    bus.ex_branch,
        branch_ne: bus.ex_branch_ne
    };

    branch_resolve u_branch_resolve (
        .branch_i (ex_ctrl.branch),
        .zero_i   (bus.ex_zero),
        .ne_i     (ex_ctrl.branch_ne),
        .taken_o  (taken_now)
    );

    // Priority flush > stall > capture > bubble; the redirect pulse is only
    // ever set on a capture, so it can never repeat across a stall.
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        target_d     = target_q;
        taken_d      = 1'b0;

        if (bus.flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (bus.stall) begin
            valid_d = valid_q;
        end else if (bus.ex_valid) begin
            valid_d      = 1'b1;
            result_d     = bus.ex_result;
            store_data_d = bus.ex_store_data;
            rd_d         = bus.ex_rd;
            reg_write_d  = ex_ctrl.reg_write;
            mem_read_d   = ex_ctrl.mem_read;
            mem_write_d  = ex_ctrl.mem_write;
            taken_d      = taken_now;
            target_d     = bus.ex_branch_target;
        end else begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
        end
    end

    assign bus.ex_ready       = ~bus.stall;
    assign bus.mem_valid      = valid_q;
    assign bus.mem_result     = result_q;
    assign bus.mem_store_data = store_data_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = valid_q & reg_write_q;
    assign bus.mem_mem_read   = valid_q & mem_read_q;
    assign bus.mem_mem_write  = valid_q & mem_write_q;
    assign bus.branch_taken   = taken_q;
    assign bus.branch_target  = target_q;
    assign bus.fwd_valid      = valid_q & reg_write_q & (rd_q != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected state pushed on drive, popped after the edge.
module tb_ex_mem_stage;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, ne;
        logic [31:0] tgt;
        logic        stall, flush;
    } stim_t;

    typedef struct {
        logic        is_reset;
        logic        valid;
        logic [31:0] result;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic        taken;
        logic [31:0] target;
        logic        fwd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb_q[$];

    logic        m_valid, m_rw, m_mr, m_mw, m_taken;
    logic [31:0] m_result, m_sd, m_target;
    logic [4:0]  m_rd;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, valid: 1'b0, result: '0, zero: 1'b0, sd: '0, rd: '0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ne: 1'b0, tgt: '0,
              stall: 1'b0, flush: 1'b0};
        return s;
    endfunction

    task automatic model_step(input stim_t s);
        exp_t e;
        if (s.rst) begin
            m_valid = 0; m_result = '0; m_sd = '0; m_rd = '0;
            m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0; m_target = '0;
        end else if (s.flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
        end else if (s.stall) begin
            m_taken = 0;
        end else if (s.valid) begin
            m_valid = 1; m_result = s.result; m_sd = s.sd; m_rd = s.rd;
            m_rw = s.rw; m_mr = s.mr; m_mw = s.mw;
            m_taken = s.br && (s.ne ? !s.zero : s.zero);
            m_target = s.tgt;
        end else begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
        end
        e.is_reset = s.rst;
        e.valid    = m_valid;
        e.result   = m_result;
        e.sd       = m_sd;
        e.rd       = m_rd;
        e.rw       = m_valid && m_rw;
        e.mr       = m_valid && m_mr;
        e.mw       = m_valid && m_mw;
        e.taken    = m_taken;
        e.target   = m_target;
        e.fwd      = m_valid && m_rw && (m_rd != 5'd0);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset                = s.rst;
        bus.ex_valid         = s.valid;
        bus.ex_result        = s.result;
        bus.ex_zero          = s.zero;
        bus.ex_store_data    = s.sd;
        bus.ex_rd            = s.rd;
        bus.ex_reg_write     = s.rw;
        bus.ex_mem_read      = s.mr;
        bus.ex_mem_write     = s.mw;
        bus.ex_branch        = s.br;
        bus.ex_branch_ne     = s.ne;
        bus.ex_branch_target = s.tgt;
        bus.stall            = s.stall;
        bus.flush            = s.flush;
        model_step(s);
        #1;
        check_val("ex_ready", 64'(bus.ex_ready), 64'(!s.stall));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            check_val("mem_valid", 64'(bus.mem_valid), 64'(e.valid));
            check_val("mem_reg_write", 64'(bus.mem_reg_write), 64'(e.rw));
            check_val("mem_mem_read", 64'(bus.mem_mem_read), 64'(e.mr));
            check_val("mem_mem_write", 64'(bus.mem_mem_write), 64'(e.mw));
            check_val("branch_taken", 64'(bus.branch_taken), 64'(e.taken));
            check_val("fwd_valid", 64'(bus.fwd_valid), 64'(e.fwd));
            if (e.valid || e.is_reset) begin
                check_val("mem_result", 64'(bus.mem_result), 64'(e.result));
                check_val("mem_store_data", 64'(bus.mem_store_data), 64'(e.sd));
                check_val("mem_rd", 64'(bus.mem_rd), 64'(e.rd));
            end
            if (e.taken || e.is_reset)
                check_val("branch_target", 64'(bus.branch_target), 64'(e.target));
        end
    endtask

    initial begin
        stim_t s;

        s = idle(); s.rst = 1'b1;
        cyc(s); cyc(s);

        // add captured, then reset mid-stream
        s = idle(); s.valid = 1; s.result = 32'h10; s.rd = 5'd2; s.rw = 1;
        cyc(s);
        s.rst = 1'b1; cyc(s);

        // add to r3, then to r0
        s = idle(); s.valid = 1; s.result = 32'h7; s.rd = 5'd3; s.rw = 1;
        cyc(s);
        s.rd = 5'd0; cyc(s);

        // beq taken, followed by a bubble
        s = idle(); s.valid = 1; s.br = 1; s.zero = 1; s.tgt = 32'h40;
        cyc(s);
        cyc(idle());

        // bne with zero=1 (not taken) and zero=0 (taken)
        s = idle(); s.valid = 1; s.br = 1; s.ne = 1; s.zero = 1; s.tgt = 32'h80;
        cyc(s);
        s.zero = 0; s.tgt = 32'hC0; cyc(s);

        // taken beq then three stalled cycles with a different instruction waiting
        s = idle(); s.valid = 1; s.br = 1; s.zero = 1; s.result = 32'h55; s.tgt = 32'h100;
        cyc(s);
        s = idle(); s.valid = 1; s.result = 32'h99; s.rd = 5'd9; s.rw = 1; s.stall = 1;
        for (int i = 0; i < 3; i++) cyc(s);

        // store captured, then flush together with stall
        s = idle(); s.valid = 1; s.mw = 1; s.sd = 32'hDEAD_BEEF; s.result = 32'h200;
        cyc(s);
        s = idle(); s.valid = 1; s.rw = 1; s.rd = 5'd4; s.flush = 1; s.stall = 1;
        cyc(s);

        // bubble with reg_write asserted on the bus
        s = idle(); s.valid = 1; s.result = 32'h3; s.rd = 5'd5; s.rw = 1;
        cyc(s);
        s = idle(); s.rw = 1; s.rd = 5'd6;
        cyc(s);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            s = idle();
            s.valid  = 1'($urandom_range(0, 3) != 0);
            s.result = $urandom;
            s.zero   = 1'($urandom_range(0, 1));
            s.sd     = $urandom;
            s.rd     = 5'($urandom_range(0, 3));
            s.rw     = 1'($urandom_range(0, 1));
            s.mr     = 1'($urandom_range(0, 1));
            s.mw     = 1'($urandom_range(0, 1));
            s.br     = 1'($urandom_range(0, 1));
            s.ne     = 1'($urandom_range(0, 1));
            s.tgt    = $urandom;
            s.stall  = 1'($urandom_range(0, 3) == 0);
            s.flush  = 1'($urandom_range(0, 7) == 0);
            s.rst    = 1'($urandom_range(0, 19) == 0);
            cyc(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
